// File: rtl/ahb_ic_pkg.sv
// rtl/ahb_ic_pkg.sv - shared AHB-Lite interconnect encodings and arbiter state type
package ahb_ic_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_t;

  // IDLE: no owner; OWNED: owner may be replaced at the next boundary;
  // HOLD: owner is mid-burst or locked and keeps the port.
  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_OWNED,
    ARB_HOLD
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotate-priority one-hot picker
module rr_pick #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_sel,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_vld
);

  // First pass covers indices from the pointer upward, second pass wraps to
  // the indices below it, so the first set bit found is the rotated winner.
  always_comb begin
    o_sel = '0;
    o_idx = '0;
    o_vld = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!o_vld && i_req[k] && (k >= int'(i_ptr))) begin
        o_sel[k] = 1'b1;
        o_idx    = IDX_W'(k);
        o_vld    = 1'b1;
      end
    end
    for (int k = 0; k < N; k++) begin
      if (!o_vld && i_req[k] && (k < int'(i_ptr))) begin
        o_sel[k] = 1'b1;
        o_idx    = IDX_W'(k);
        o_vld    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/slave_port_arbiter.sv
// rtl/slave_port_arbiter.sv - per-slave round-robin AHB-Lite arbiter with burst/lock hold
module slave_port_arbiter
  import ahb_ic_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int MIDX_W      = 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [NUM_MASTERS-1:0] i_req,
  input  logic [NUM_MASTERS-1:0] i_seq,
  input  logic [NUM_MASTERS-1:0] i_lock,
  input  logic                   i_shready,
  output logic [NUM_MASTERS-1:0] o_addr_sel,
  output logic [MIDX_W-1:0]      o_addr_idx,
  output logic                   o_addr_vld,
  output logic [NUM_MASTERS-1:0] o_data_sel,
  output logic                   o_data_vld,
  output logic [NUM_MASTERS-1:0] o_stall
);

  localparam logic [MIDX_W-1:0] LAST_IDX = MIDX_W'(NUM_MASTERS - 1);

  // A single master needs no arbiter; refuse to build one.
  if (NUM_MASTERS < 2 || NUM_MASTERS > 8) begin : g_bad_num_masters
    $error("slave_port_arbiter: NUM_MASTERS must be 2..8");
  end
  if (MIDX_W != $clog2(NUM_MASTERS)) begin : g_bad_midx_w
    $error("slave_port_arbiter: MIDX_W must equal clog2(NUM_MASTERS)");
  end

  arb_state_t             state_q, state_d;
  logic [NUM_MASTERS-1:0] addr_sel_q, addr_sel_d;
  logic [MIDX_W-1:0]      addr_idx_q, addr_idx_d;
  logic                   addr_vld_q, addr_vld_d;
  logic [NUM_MASTERS-1:0] data_sel_q, data_sel_d;
  logic                   data_vld_q, data_vld_d;
  logic [MIDX_W-1:0]      rr_ptr_q, rr_ptr_d;

  logic [NUM_MASTERS-1:0] others;
  logic [NUM_MASTERS-1:0] pick_req;
  logic [NUM_MASTERS-1:0] pick_sel;
  logic [MIDX_W-1:0]      pick_idx;
  logic                   pick_vld;
  logic                   owner_cont;
  logic                   do_grant;
  logic                   go_idle;

  // The current owner only competes when nobody else is asking.
  assign others     = i_req & ~addr_sel_q;
  assign pick_req   = (others != '0) ? others : i_req;
  assign owner_cont = |(addr_sel_q & i_req & (i_seq | i_lock));

  rr_pick #(
    .N     (NUM_MASTERS),
    .IDX_W (MIDX_W)
  ) u_pick (
    .i_req (pick_req),
    .i_ptr (rr_ptr_q),
    .o_sel (pick_sel),
    .o_idx (pick_idx),
    .o_vld (pick_vld)
  );

  // Next-state: arbitrate only at transfer boundaries, otherwise hold everything.
  always_comb begin
    state_d    = state_q;
    addr_sel_d = addr_sel_q;
    addr_idx_d = addr_idx_q;
    addr_vld_d = addr_vld_q;
    data_sel_d = data_sel_q;
    data_vld_d = data_vld_q;
    rr_ptr_d   = rr_ptr_q;
    do_grant   = 1'b0;
    go_idle    = 1'b0;
    if (i_shready) begin
      data_sel_d = addr_sel_q;
      data_vld_d = addr_vld_q;
      case (state_q)
        ARB_IDLE: begin
          do_grant = pick_vld;
        end
        ARB_OWNED, ARB_HOLD: begin
          if (owner_cont) begin
            state_d = ARB_HOLD;
          end else if (pick_vld) begin
            do_grant = 1'b1;
          end else begin
            go_idle = 1'b1;
          end
        end
        default: begin
          go_idle = 1'b1;
        end
      endcase
      if (do_grant) begin
        addr_sel_d = pick_sel;
        addr_idx_d = pick_idx;
        addr_vld_d = 1'b1;
        rr_ptr_d   = (pick_idx == LAST_IDX) ? '0 : pick_idx + MIDX_W'(1);
        state_d    = (|(pick_sel & i_lock)) ? ARB_HOLD : ARB_OWNED;
      end
      if (go_idle) begin
        addr_sel_d = '0;
        addr_idx_d = '0;
        addr_vld_d = 1'b0;
        state_d    = ARB_IDLE;
      end
    end
  end

  // State, grant and data-phase registers; reset drops every grant immediately.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= ARB_IDLE;
      addr_sel_q <= '0;
      addr_idx_q <= '0;
      addr_vld_q <= 1'b0;
      data_sel_q <= '0;
      data_vld_q <= 1'b0;
      rr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      addr_sel_q <= addr_sel_d;
      addr_idx_q <= addr_idx_d;
      addr_vld_q <= addr_vld_d;
      data_sel_q <= data_sel_d;
      data_vld_q <= data_vld_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  assign o_addr_sel = addr_sel_q;
  assign o_addr_idx = addr_idx_q;
  assign o_addr_vld = addr_vld_q;
  assign o_data_sel = data_sel_q;
  assign o_data_vld = data_vld_q;
  assign o_stall    = i_req & ~addr_sel_q;

endmodule

// File: tb/tb_slave_port_arbiter.sv
// tb/tb_slave_port_arbiter.sv - scoreboard bench for slave_port_arbiter (2 and 4 masters)
module tb_slave_port_arbiter;

  typedef struct packed {
    logic [3:0] asel;
    logic [1:0] aidx;
    logic       avld;
    logic [3:0] dsel;
    logic       dvld;
    logic [3:0] stall;
  } exp_t;

  typedef struct packed {
    logic       rst_n;
    logic       rdy;
    logic [3:0] req;
    logic [3:0] seq;
    logic [3:0] lock;
    logic [3:0] asel;
    logic [1:0] aidx;
    logic       avld;
  } stim_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst2_n, rdy2;
  logic [1:0] req2, seq2, lock2;
  logic [1:0] a_sel2, d_sel2, stall2;
  logic       a_idx2, a_vld2, d_vld2;

  logic       rst4_n, rdy4;
  logic [3:0] req4, seq4, lock4;
  logic [3:0] a_sel4, d_sel4, stall4;
  logic [1:0] a_idx4;
  logic       a_vld4, d_vld4;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t e;

  slave_port_arbiter #(.NUM_MASTERS(2), .MIDX_W(1)) dut2 (
    .i_clk(clk), .i_rst_n(rst2_n), .i_req(req2), .i_seq(seq2), .i_lock(lock2),
    .i_shready(rdy2), .o_addr_sel(a_sel2), .o_addr_idx(a_idx2), .o_addr_vld(a_vld2),
    .o_data_sel(d_sel2), .o_data_vld(d_vld2), .o_stall(stall2)
  );

  slave_port_arbiter #(.NUM_MASTERS(4), .MIDX_W(2)) dut4 (
    .i_clk(clk), .i_rst_n(rst4_n), .i_req(req4), .i_seq(seq4), .i_lock(lock4),
    .i_shready(rdy4), .o_addr_sel(a_sel4), .o_addr_idx(a_idx4), .o_addr_vld(a_vld4),
    .o_data_sel(d_sel4), .o_data_vld(d_vld4), .o_stall(stall4)
  );

  function automatic string fmt(input exp_t v);
    return $sformatf("asel=%b idx=%0d vld=%b dsel=%b dvld=%b stall=%b",
                     v.asel, v.aidx, v.avld, v.dsel, v.dvld, v.stall);
  endfunction

  function automatic exp_t snap2();
    return {{2'b00, a_sel2}, {1'b0, a_idx2}, a_vld2, {2'b00, d_sel2}, d_vld2, {2'b00, stall2}};
  endfunction

  function automatic exp_t snap4();
    return {a_sel4, a_idx4, a_vld4, d_sel4, d_vld4, stall4};
  endfunction

  // Expected post-edge outputs: reset clears, a boundary shifts address into
  // data and takes the new grant, a wait state freezes both.
  task automatic push(input stim_t s);
    if (!s.rst_n) begin
      e = '0;
    end else if (s.rdy) begin
      e.dsel = e.asel;
      e.dvld = e.avld;
      e.asel = s.asel;
      e.aidx = s.aidx;
      e.avld = s.avld;
    end
    e.stall = s.req & ~e.asel;
    sb.push_back(e);
  endtask

  task automatic drive2(input stim_t s);
    rst2_n = s.rst_n; rdy2 = s.rdy;
    req2 = s.req[1:0]; seq2 = s.seq[1:0]; lock2 = s.lock[1:0];
  endtask

  task automatic drive4(input stim_t s);
    rst4_n = s.rst_n; rdy4 = s.rdy;
    req4 = s.req; seq4 = s.seq; lock4 = s.lock;
  endtask

  task automatic test_reset();
    stim_t t[6] = '{
      '{1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0},
      '{1'b1, 1'b1, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 2'd1, 1'b1},
      '{1'b1, 1'b1, 4'b0010, 4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b1},
      '{1'b0, 1'b0, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 2'd0, 1'b0},
      '{1'b1, 1'b1, 4'b0011, 4'b0000, 4'b0000, 4'b0001, 2'd0, 1'b1},
      '{1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0}
    };
    exp_t x, obs;
    e = '0;
    foreach (t[i]) begin
      drive2(t[i]);
      push(t[i]);
      @(posedge clk); #1;
      x = sb.pop_front();
      obs = snap2();
      checks++;
      if (obs !== x) begin
        errors++;
        $display("FAIL reset step %0d: got %s, want %s", i, fmt(obs), fmt(x));
      end
    end
  endtask

  task automatic test_alternate();
    stim_t t[8] = '{
      '{1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0},
      '{1'b1, 1'b1, 4'b0011, 4'b0000, 4'b0000, 4'b0001, 2'd0, 1'b1},
      '{1'b1, 1'b1, 4'b0011, 4'b0000, 4'b0000, 4'b0010, 2'd1, 1'b1},
      '{1'b1, 1'b1, 4'b0011, 4'b0000, 4'b0000, 4'b0001, 2'd0, 1'b1},
      '{1'b1, 1'b1, 4'b0011, 4'b0000, 4'b0000, 4'b0010, 2'd1, 1'b1},
      '{1'b1, 1'b1, 4'b0011, 4'b0000, 4'b0000, 4'b0001, 2'd0, 1'b1},
      '{1'b1, 1'b1, 4'b0011, 4'b0000, 4'b0000, 4'b0010, 2'd1, 1'b1},
      '{1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0}
    };
    exp_t x, obs;
    foreach (t[i]) begin
      drive2(t[i]);
      push(t[i]);
      @(posedge clk); #1;
      x = sb.pop_front();
      obs = snap2();
      checks++;
      if (obs !== x) begin
        errors++;
        $display("FAIL alternate step %0d: got %s, want %s", i, fmt(obs), fmt(x));
      end
    end
  endtask

  task automatic test_burst();
    stim_t t[6] = '{
      '{1'b1, 1'b1, 4'b0011, 4'b0000, 4'b0000, 4'b0001, 2'd0, 1'b1},
      '{1'b1, 1'b1, 4'b0011, 4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b1},
      '{1'b1, 1'b1, 4'b0011, 4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b1},
      '{1'b1, 1'b1, 4'b0011, 4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b1},
      '{1'b1, 1'b1, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 2'd1, 1'b1},
      '{1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0}
    };
    exp_t x, obs;
    foreach (t[i]) begin
      drive2(t[i]);
      push(t[i]);
      @(posedge clk); #1;
      x = sb.pop_front();
      obs = snap2();
      checks++;
      if (obs !== x) begin
        errors++;
        $display("FAIL burst step %0d: got %s, want %s", i, fmt(obs), fmt(x));
      end
    end
  endtask

  task automatic test_wait_states();
    stim_t t[6] = '{
      '{1'b1, 1'b1, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 2'd1, 1'b1},
      '{1'b1, 1'b0, 4'b0011, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0},
      '{1'b1, 1'b0, 4'b0011, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0},
      '{1'b1, 1'b0, 4'b0011, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0},
      '{1'b1, 1'b1, 4'b0011, 4'b0000, 4'b0000, 4'b0001, 2'd0, 1'b1},
      '{1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0}
    };
    exp_t x, obs;
    foreach (t[i]) begin
      drive2(t[i]);
      push(t[i]);
      @(posedge clk); #1;
      x = sb.pop_front();
      obs = snap2();
      checks++;
      if (obs !== x) begin
        errors++;
        $display("FAIL wait_states step %0d: got %s, want %s", i, fmt(obs), fmt(x));
      end
    end
  endtask

  task automatic test_lock();
    stim_t t[5] = '{
      '{1'b1, 1'b1, 4'b0010, 4'b0000, 4'b0010, 4'b0010, 2'd1, 1'b1},
      '{1'b1, 1'b1, 4'b0011, 4'b0000, 4'b0010, 4'b0010, 2'd1, 1'b1},
      '{1'b1, 1'b1, 4'b0011, 4'b0000, 4'b0010, 4'b0010, 2'd1, 1'b1},
      '{1'b1, 1'b1, 4'b0011, 4'b0000, 4'b0000, 4'b0001, 2'd0, 1'b1},
      '{1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0}
    };
    exp_t x, obs;
    foreach (t[i]) begin
      drive2(t[i]);
      push(t[i]);
      @(posedge clk); #1;
      x = sb.pop_front();
      obs = snap2();
      checks++;
      if (obs !== x) begin
        errors++;
        $display("FAIL lock step %0d: got %s, want %s", i, fmt(obs), fmt(x));
      end
    end
  endtask

  task automatic test_four_masters();
    stim_t t[9] = '{
      '{1'b1, 1'b1, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 2'd2, 1'b1},
      '{1'b0, 1'b1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0},
      '{1'b1, 1'b1, 4'b1111, 4'b0000, 4'b0000, 4'b0001, 2'd0, 1'b1},
      '{1'b1, 1'b1, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 2'd2, 1'b1},
      '{1'b1, 1'b1, 4'b1111, 4'b0000, 4'b0000, 4'b1000, 2'd3, 1'b1},
      '{1'b1, 1'b1, 4'b1111, 4'b0000, 4'b0000, 4'b0001, 2'd0, 1'b1},
      '{1'b1, 1'b1, 4'b1111, 4'b0000, 4'b0000, 4'b0010, 2'd1, 1'b1},
      '{1'b1, 1'b1, 4'b1111, 4'b0000, 4'b0000, 4'b0100, 2'd2, 1'b1},
      '{1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0}
    };
    exp_t x, obs;
    e = '0;
    foreach (t[i]) begin
      drive4(t[i]);
      push(t[i]);
      @(posedge clk); #1;
      x = sb.pop_front();
      obs = snap4();
      checks++;
      if (obs !== x) begin
        errors++;
        $display("FAIL four_masters step %0d: got %s, want %s", i, fmt(obs), fmt(x));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst2_n = 1'b0; rdy2 = 1'b1; req2 = '0; seq2 = '0; lock2 = '0;
    rst4_n = 1'b0; rdy4 = 1'b1; req4 = '0; seq4 = '0; lock4 = '0;
    test_reset();
    test_alternate();
    test_burst();
    test_wait_states();
    test_lock();
    test_four_masters();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
